// File: rtl/v810_bus_responder.sv
// v810_bus_responder: target end of the v810_mem bus. Decodes cycles that fall in
// its window and answers them from a synchronous RAM, with programmable waits and 16-bit sizing.
module v810_bus_responder #(
  parameter int          AW   = 10,
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter logic [31:0] MASK = 32'h8000_0000,
  parameter bit          IO   = 1'b0
) (
  input  logic          CLK,
  input  logic          RESn,
  input  logic          CE,
  input  logic [31:0]   A,
  input  logic [31:0]   D_I,
  output logic [31:0]   D_O,
  input  logic [3:0]    BEn,
  input  logic [1:0]    ST,
  input  logic          DAn,
  input  logic          MRQn,
  input  logic          RW,
  input  logic          BCYSTn,
  output logic          READYn,
  output logic          SZRQn,
  input  logic [3:0]    WS,
  input  logic          DW16,
  output logic [AW-1:0] MEM_A,
  output logic [31:0]   MEM_DI,
  input  logic [31:0]   MEM_DO,
  output logic [3:0]    MEM_BEn,
  output logic          MEM_nCE,
  output logic          MEM_nWE
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rw_q, rw_d;
  logic          w16_q, w16_d;
  logic          a1_q, a1_d;
  logic [3:0]    ben_q, ben_d;
  logic          ready_n_q, ready_n_d;
  logic          szrq_n_q, szrq_n_d;
  logic [31:0]   d_o_q, d_o_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [31:0]   mem_di_q, mem_di_d;
  logic [3:0]    mem_ben_q, mem_ben_d;
  logic          mem_nce_q, mem_nce_d;
  logic          mem_nwe_q, mem_nwe_d;

  logic          addr_hit;
  logic          space_hit;
  logic          sel;
  logic [15:0]   rd_half;
  logic [31:0]   rd_fmt;

  function automatic logic [31:0] wr_data(input logic [31:0] d, input logic w16);
    return w16 ? {d[15:0], d[15:0]} : d;
  endfunction

  function automatic logic [3:0] wr_ben(input logic [3:0] be, input logic w16, input logic a1);
    if (!w16) return be;
    return a1 ? 4'b0011 : 4'b1100;
  endfunction

  assign addr_hit  = ((A ^ BASE) & MASK) == 32'h0;
  assign space_hit = IO ? (MRQn && (ST == 2'b10)) : ~MRQn;
  // A new cycle is accepted from IDLE or DONE only; a T1 seen while busy is dropped.
  assign sel       = RESn && CE && ~BCYSTn && addr_hit && space_hit && (state_q != S_ACC);

  assign rd_half = a1_q ? MEM_DO[31:16] : MEM_DO[15:0];
  assign rd_fmt  = w16_q ? {rd_half, rd_half} : MEM_DO;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    w16_d     = w16_q;
    a1_d      = a1_q;
    ben_d     = ben_q;
    ready_n_d = ready_n_q;
    szrq_n_d  = szrq_n_q;
    d_o_d     = d_o_q;
    mem_a_d   = mem_a_q;
    mem_di_d  = mem_di_q;
    mem_ben_d = mem_ben_q;
    mem_nce_d = mem_nce_q;
    mem_nwe_d = mem_nwe_q;
    if (CE) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d   = S_IDLE;
          ready_n_d = 1'b0;
          szrq_n_d  = 1'b1;
          mem_nce_d = 1'b1;
          mem_nwe_d = 1'b1;
          mem_ben_d = 4'hF;
          if (sel) begin
            state_d   = S_ACC;
            cnt_d     = WS;
            rw_d      = RW;
            w16_d     = DW16;
            a1_d      = A[1];
            ben_d     = BEn;
            mem_a_d   = A[AW+1:2];
            ready_n_d = (WS != 4'd0);
            szrq_n_d  = ~DW16;
            mem_nce_d = ~RW;
            if (!RW && (WS == 4'd0)) begin
              mem_nce_d = 1'b0;
              mem_nwe_d = 1'b0;
              mem_di_d  = wr_data(D_I, DW16);
              mem_ben_d = wr_ben(BEn, DW16, A[1]);
            end
          end
        end
        S_ACC: begin
          if (rw_q) d_o_d = rd_fmt;
          if (!DAn) begin
            if (cnt_q != 4'd0) begin
              cnt_d     = cnt_q - 4'd1;
              ready_n_d = (cnt_q != 4'd1);
              // The write strobe lands exactly in the cycle READYn drops.
              if (!rw_q && (cnt_q == 4'd1)) begin
                mem_nce_d = 1'b0;
                mem_nwe_d = 1'b0;
                mem_di_d  = wr_data(D_I, w16_q);
                mem_ben_d = wr_ben(ben_q, w16_q, a1_q);
              end
            end else begin
              state_d   = S_DONE;
              ready_n_d = 1'b0;
              szrq_n_d  = 1'b1;
              mem_nce_d = 1'b1;
              mem_nwe_d = 1'b1;
              mem_ben_d = 4'hF;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      rw_q      <= 1'b0;
      w16_q     <= 1'b0;
      a1_q      <= 1'b0;
      ben_q     <= 4'hF;
      ready_n_q <= 1'b0;
      szrq_n_q  <= 1'b1;
      d_o_q     <= 32'h0;
      mem_a_q   <= '0;
      mem_di_q  <= 32'h0;
      mem_ben_q <= 4'hF;
      mem_nce_q <= 1'b1;
      mem_nwe_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      w16_q     <= w16_d;
      a1_q      <= a1_d;
      ben_q     <= ben_d;
      ready_n_q <= ready_n_d;
      szrq_n_q  <= szrq_n_d;
      d_o_q     <= d_o_d;
      mem_a_q   <= mem_a_d;
      mem_di_q  <= mem_di_d;
      mem_ben_q <= mem_ben_d;
      mem_nce_q <= mem_nce_d;
      mem_nwe_q <= mem_nwe_d;
    end
  end

  // Address and read enable bypass the registers in T1 so RAM data is ready for a zero-wait T2.
  assign MEM_A   = sel ? A[AW+1:2] : mem_a_q;
  assign MEM_nCE = (sel && RW) ? 1'b0 : mem_nce_q;
  assign D_O     = ((state_q == S_ACC) && rw_q) ? rd_fmt : d_o_q;
  assign READYn  = ready_n_q;
  assign SZRQn   = szrq_n_q;
  assign MEM_DI  = mem_di_q;
  assign MEM_BEn = mem_ben_q;
  assign MEM_nWE = mem_nwe_q;

endmodule

// File: tb/tb_v810_bus_responder.sv
// Bench for v810_bus_responder: a bus master drives directed cycles while a RAM model
// answers the memory port and a per-cycle comparator checks outputs against expectations.
module tb_v810_bus_responder;

  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RESn = 1'b1;
  logic          CE = 1'b1;
  logic [31:0]   A = 32'h0;
  logic [31:0]   D_I = 32'h0;
  logic [31:0]   D_O;
  logic [3:0]    BEn = 4'hF;
  logic [1:0]    ST = 2'b00;
  logic          DAn = 1'b1;
  logic          MRQn = 1'b0;
  logic          RW = 1'b1;
  logic          BCYSTn = 1'b1;
  logic          READYn;
  logic          SZRQn;
  logic [3:0]    WS = 4'd0;
  logic          DW16 = 1'b0;
  logic [AW-1:0] MEM_A;
  logic [31:0]   MEM_DI;
  logic [31:0]   MEM_DO = 32'h0;
  logic [3:0]    MEM_BEn;
  logic          MEM_nCE;
  logic          MEM_nWE;

  int checks = 0;
  int errors = 0;
  int rdy_hi_cnt = 0;
  int nce_lo_cnt = 0;

  logic        chk_en = 1'b0;
  logic        exp_readyn = 1'b0;
  logic        exp_szrqn = 1'b1;
  logic [31:0] exp_do = 32'h0;
  logic        exp_nwe = 1'b1;
  logic        nce_chk = 1'b1;
  logic        exp_nce = 1'b1;
  logic        ben_chk = 1'b0;
  logic [3:0]  exp_ben = 4'hF;

  logic [31:0] ram     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic [31:0] rd;

  v810_bus_responder #(.AW(AW)) dut (
    .CLK(CLK), .RESn(RESn), .CE(CE), .A(A), .D_I(D_I), .D_O(D_O), .BEn(BEn), .ST(ST),
    .DAn(DAn), .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn), .READYn(READYn), .SZRQn(SZRQn),
    .WS(WS), .DW16(DW16), .MEM_A(MEM_A), .MEM_DI(MEM_DI), .MEM_DO(MEM_DO),
    .MEM_BEn(MEM_BEn), .MEM_nCE(MEM_nCE), .MEM_nWE(MEM_nWE)
  );

  always #5 CLK = ~CLK;

  // Synchronous RAM device: registered read, byte-masked write.
  always @(posedge CLK) begin
    if (CE && !MEM_nCE) begin
      if (!MEM_nWE) begin
        for (int b = 0; b < 4; b++)
          if (!MEM_BEn[b]) ram[MEM_A][8*b +: 8] <= MEM_DI[8*b +: 8];
      end else begin
        MEM_DO <= ram[MEM_A];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (READYn === 1'b1) rdy_hi_cnt++;
    if (MEM_nCE === 1'b0) nce_lo_cnt++;
    if (chk_en) begin
      check("READYn", {31'h0, READYn}, {31'h0, exp_readyn});
      check("SZRQn", {31'h0, SZRQn}, {31'h0, exp_szrqn});
      check("D_O", D_O, exp_do);
      check("MEM_nWE", {31'h0, MEM_nWE}, {31'h0, exp_nwe});
      if (nce_chk) check("MEM_nCE", {31'h0, MEM_nCE}, {31'h0, exp_nce});
      if (ben_chk) check("MEM_BEn", {28'h0, MEM_BEn}, {28'h0, exp_ben});
    end
  end

  function automatic logic [31:0] init_word(input int i);
    logic [15:0] iv;
    iv = i[15:0];
    case (i)
      1:       return 32'hAAAA_5555;
      2:       return 32'h1357_9BDF;
      4:       return 32'h1234_5678;
      8:       return 32'h0F0F_F0F0;
      default: return {iv ^ 16'h5A5A, ~iv};
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] w, input logic dw16,
                                             input logic a1);
    if (!dw16) return w;
    return a1 ? {w[31:16], w[31:16]} : {w[15:0], w[15:0]};
  endfunction

  task automatic set_quiet();
    exp_readyn = 1'b0;
    exp_szrqn  = 1'b1;
    exp_nwe    = 1'b1;
    nce_chk    = 1'b1;
    exp_nce    = 1'b1;
    ben_chk    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      BCYSTn = 1'b1;
      DAn    = 1'b1;
      set_quiet();
    end
  endtask

  // One bus cycle: T1 then DAn cycles until the expected ready. gap_at inserts three
  // CE-low cycles before DAn cycle gap_at; abort_at asserts reset during that DAn cycle.
  task automatic bus_cycle(input logic [31:0] addr, input logic rw, input logic [3:0] ben,
                           input logic [31:0] wdata, input int ws, input logic dw16,
                           input logic mrqn, input logic [1:0] st, input int gap_at,
                           input int abort_at, output logic [31:0] rdata);
    logic          selected;
    logic [AW-1:0] idx;
    int            last;
    selected = ((addr & 32'h8000_0000) == 32'h0) && !mrqn;
    idx      = addr[AW+1:2];
    last     = selected ? ws : 0;
    rdata    = 32'h0;
    @(posedge CLK); #1;
    A = addr; RW = rw; BEn = ben; D_I = wdata; WS = 4'(ws); DW16 = dw16;
    MRQn = mrqn; ST = st; BCYSTn = 1'b0; DAn = 1'b1;
    set_quiet();
    nce_chk = !(selected && rw);
    for (int k = 0; k <= last; k++) begin
      @(posedge CLK); #1;
      BCYSTn = 1'b1;
      DAn    = 1'b0;
      if (k == abort_at) begin
        #2 RESn = 1'b0;
        set_quiet();
        exp_do = 32'h0;
        #1;
        check("rst_READYn", {31'h0, READYn}, 32'h0);
        check("rst_SZRQn", {31'h0, SZRQn}, 32'h1);
        check("rst_D_O", D_O, 32'h0);
        check("rst_MEM_nCE", {31'h0, MEM_nCE}, 32'h1);
        check("rst_MEM_nWE", {31'h0, MEM_nWE}, 32'h1);
        check("rst_MEM_BEn", {28'h0, MEM_BEn}, 32'hF);
        check("rst_MEM_A", {{(32-AW){1'b0}}, MEM_A}, 32'h0);
        check("rst_MEM_DI", MEM_DI, 32'h0);
        DAn = 1'b1;
        $display("txn %s addr=%h ws=%0d dw16=%0b aborted by reset in wait %0d",
                 rw ? "RD" : "WR", addr, ws, dw16, k);
        return;
      end
      exp_readyn = selected && (k < ws);
      exp_szrqn  = selected ? !dw16 : 1'b1;
      if (selected && rw && k == 0) exp_do = model_read(ref_mem[idx], dw16, addr[1]);
      exp_nwe = !(selected && !rw && k == ws);
      nce_chk = !(selected && rw);
      exp_nce = exp_nwe;
      ben_chk = !exp_nwe;
      exp_ben = dw16 ? (addr[1] ? 4'b0011 : 4'b1100) : ben;
      if (k == gap_at) begin
        CE = 1'b0;
        repeat (3) @(posedge CLK);
        #1 CE = 1'b1;
      end
      if (k == 0) begin
        @(negedge CLK);
        rdata = D_O;
      end
    end
    if (selected && !rw) begin
      if (dw16) begin
        if (addr[1]) ref_mem[idx][31:16] = wdata[15:0];
        else         ref_mem[idx][15:0]  = wdata[15:0];
      end else begin
        for (int b = 0; b < 4; b++)
          if (!ben[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    $display("txn %s addr=%h ws=%0d dw16=%0b sel=%0b data=%h",
             rw ? "RD" : "WR", addr, ws, dw16, selected, rw ? rdata : wdata);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     <= init_word(i);
      ref_mem[i]  = init_word(i);
    end
    #1 RESn = 1'b0;
    #2;
    check("reset_READYn", {31'h0, READYn}, 32'h0);
    check("reset_SZRQn", {31'h0, SZRQn}, 32'h1);
    check("reset_D_O", D_O, 32'h0);
    check("reset_MEM_nCE", {31'h0, MEM_nCE}, 32'h1);
    check("reset_MEM_nWE", {31'h0, MEM_nWE}, 32'h1);
    check("reset_MEM_BEn", {28'h0, MEM_BEn}, 32'hF);
    check("reset_MEM_A", {{(32-AW){1'b0}}, MEM_A}, 32'h0);
    chk_en = 1'b1;
    @(posedge CLK); #1 RESn = 1'b1;
    idle(2);

    // Zero-wait 32-bit read.
    bus_cycle(32'h0000_0010, 1'b1, 4'h0, 32'h0, 0, 1'b0, 1'b0, 2'b00, -1, -1, rd);
    check("rd_ws0_data", rd, 32'h1234_5678);
    idle(2);

    // Three-wait write of the low halfword only.
    rdy_hi_cnt = 0;
    bus_cycle(32'h0000_0008, 1'b0, 4'b1100, 32'hDEAD_BEEF, 3, 1'b0, 1'b0, 2'b00, -1, -1, rd);
    idle(1);
    check("wr_ws3_wait_cycles", rdy_hi_cnt, 32'd3);
    check("wr_ws3_ram2", ram[2], 32'h1357_BEEF);
    idle(1);

    // 16-bit device: a 32-bit read as two halfword cycles.
    bus_cycle(32'h0000_0004, 1'b1, 4'h0, 32'h0, 1, 1'b1, 1'b0, 2'b00, -1, -1, rd);
    check("rd16_lo", {16'h0, rd[15:0]}, 32'h5555);
    check("rd16_lo_dup", rd, 32'h5555_5555);
    bus_cycle(32'h0000_0006, 1'b1, 4'h0, 32'h0, 0, 1'b1, 1'b0, 2'b00, -1, -1, rd);
    check("rd16_hi", {16'h0, rd[15:0]}, 32'hAAAA);
    idle(1);

    // 16-bit write to the upper halfword lane.
    bus_cycle(32'h0000_0022, 1'b0, 4'h0, 32'h1234_CAFE, 1, 1'b1, 1'b0, 2'b00, -1, -1, rd);
    idle(1);
    check("wr16_ram8", ram[8], 32'hCAFE_F0F0);

    // Outside window and halt acknowledge must leave the RAM untouched.
    nce_lo_cnt = 0;
    bus_cycle(32'h8000_0010, 1'b1, 4'h0, 32'h0, 2, 1'b0, 1'b0, 2'b00, -1, -1, rd);
    bus_cycle(32'h0000_0010, 1'b1, 4'h0, 32'h0, 2, 1'b0, 1'b1, 2'b01, -1, -1, rd);
    idle(1);
    check("unsel_no_nce", nce_lo_cnt, 32'd0);
    check("unsel_do_held", rd, 32'hAAAA_AAAA);

    // Back-to-back reads, each with its own wait count.
    bus_cycle(32'h0000_0008, 1'b1, 4'h0, 32'h0, 2, 1'b0, 1'b0, 2'b00, -1, -1, rd);
    check("b2b_first", rd, 32'h1357_BEEF);
    bus_cycle(32'h0000_0020, 1'b1, 4'h0, 32'h0, 1, 1'b0, 1'b0, 2'b00, -1, -1, rd);
    check("b2b_second", rd, 32'hCAFE_F0F0);
    idle(2);

    // CE stalls in the middle of a read and of a write.
    bus_cycle(32'h0000_0010, 1'b1, 4'h0, 32'h0, 4, 1'b0, 1'b0, 2'b00, 2, -1, rd);
    check("ce_gap_rd", rd, 32'h1234_5678);
    bus_cycle(32'h0000_0030, 1'b0, 4'h0, 32'h0BAD_F00D, 2, 1'b0, 1'b0, 2'b00, 1, -1, rd);
    idle(1);
    check("ce_gap_wr", ram[12], 32'h0BAD_F00D);

    // Reset in a wait state of a write abandons it.
    bus_cycle(32'h0000_0008, 1'b0, 4'h0, 32'hFFFF_FFFF, 5, 1'b0, 1'b0, 2'b00, -1, 2, rd);
    repeat (2) @(posedge CLK);
    #1 RESn = 1'b1;
    idle(3);
    check("abort_ram2", ram[2], 32'h1357_BEEF);
    bus_cycle(32'h0000_0008, 1'b1, 4'h0, 32'h0, 0, 1'b0, 1'b0, 2'b00, -1, -1, rd);
    check("post_reset_rd", rd, 32'h1357_BEEF);
    idle(2);

    for (int i = 0; i < 16; i++) check("ram_vs_model", ram[i], ref_mem[i]);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
